// File: rtl/serv_mem_pkg.sv
// Shared types and constants for the SerV ibus/dbus to SPI-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serv_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D,
        S_RESP
    } arb_state_t;

    localparam int DEF_MEM_ADR_W = 14;
    localparam logic [3:0] IBUS_FULL_SEL = 4'b1111;

endpackage

// File: rtl/ifetch_line_buf.sv
// One-word instruction buffer: tag (word address), data and valid, with a hit compare and an invalidate port.
// Latency: hit/hit_dat are combinational from lookup_adr; fills and invalidates take effect on the next edge.
// Backpressure: none; fill and invalidate are single-cycle strobes from the arbiter.
module ifetch_line_buf #(
    parameter int ADR_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADR_W-1:0] lookup_adr,
    output logic             hit,
    output logic [31:0]      hit_dat,
    input  logic             fill_en,
    input  logic [ADR_W-1:0] fill_adr,
    input  logic [31:0]      fill_dat,
    input  logic             inval_en,
    input  logic [ADR_W-1:0] inval_adr
);

    logic             vld_q, vld_d;
    logic [ADR_W-1:0] tag_q, tag_d;
    logic [31:0]      dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        dat_d = dat_q;
        if (inval_en && (inval_adr == tag_q)) begin
            vld_d = 1'b0;
        end
        if (fill_en) begin
            vld_d = 1'b1;
            tag_d = fill_adr;
            dat_d = fill_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            tag_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
        end
    end

    assign hit     = vld_q && (tag_q == lookup_adr);
    assign hit_dat = dat_q;

endmodule

// File: rtl/serv_mem_arbiter.sv
// Fixed-priority (dbus first) Wishbone arbiter from SerV ibus/dbus onto the SPI memory slave; IBUS_LINE_BUF_EN adds a one-word fetch buffer.
// Latency: ack one cycle after m_ack; out-of-range or buffer hit acks in the cycle after cyc is sampled.
// Backpressure: one transaction in flight; the losing master simply keeps cyc high until it is served.
module serv_mem_arbiter
    import serv_mem_pkg::*;
#(
    parameter int MEM_ADR_W = DEF_MEM_ADR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          ibus_adr,
    input  logic                 ibus_cyc,
    output logic [31:0]          ibus_rdt,
    output logic                 ibus_ack,
    input  logic [31:0]          dbus_adr,
    input  logic [31:0]          dbus_dat,
    input  logic [3:0]           dbus_sel,
    input  logic                 dbus_we,
    input  logic                 dbus_cyc,
    output logic [31:0]          dbus_rdt,
    output logic                 dbus_ack,
    output logic                 m_cyc,
    output logic [MEM_ADR_W-1:0] m_adr,
    output logic                 m_we,
    output logic [31:0]          m_dat,
    output logic [3:0]           m_sel,
    input  logic [31:0]          m_rdt,
    input  logic                 m_ack
);

    arb_state_t           state_q, state_d;
    logic                 owner_d_q, owner_d_d;
    logic                 m_cyc_q, m_cyc_d;
    logic [MEM_ADR_W-1:0] m_adr_q, m_adr_d;
    logic                 m_we_q, m_we_d;
    logic [31:0]          m_dat_q, m_dat_d;
    logic [3:0]           m_sel_q, m_sel_d;
    logic                 ibus_ack_q, ibus_ack_d;
    logic                 dbus_ack_q, dbus_ack_d;
    logic [31:0]          ibus_rdt_q, ibus_rdt_d;
    logic [31:0]          dbus_rdt_q, dbus_rdt_d;

    logic        i_in_range, d_in_range;
    logic        lb_hit, lb_fill, lb_inval;
    logic [31:0] lb_dat;
    logic        unused_adr_bits;

    assign i_in_range      = ~|ibus_adr[31:MEM_ADR_W+2];
    assign d_in_range      = ~|dbus_adr[31:MEM_ADR_W+2];
    assign unused_adr_bits = ^{ibus_adr[1:0], dbus_adr[1:0]};

`ifdef IBUS_LINE_BUF_EN
    ifetch_line_buf #(
        .ADR_W (MEM_ADR_W)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_adr (ibus_adr[MEM_ADR_W+1:2]),
        .hit        (lb_hit),
        .hit_dat    (lb_dat),
        .fill_en    (lb_fill),
        .fill_adr   (m_adr_q),
        .fill_dat   (m_rdt),
        .inval_en   (lb_inval),
        .inval_adr  (dbus_adr[MEM_ADR_W+1:2])
    );
`else
    logic unused_lb;
    assign lb_hit    = 1'b0;
    assign lb_dat    = '0;
    assign unused_lb = lb_fill ^ lb_inval;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d_d  = owner_d_q;
        m_cyc_d    = m_cyc_q;
        m_adr_d    = m_adr_q;
        m_we_d     = m_we_q;
        m_dat_d    = m_dat_q;
        m_sel_d    = m_sel_q;
        ibus_ack_d = 1'b0;
        dbus_ack_d = 1'b0;
        ibus_rdt_d = ibus_rdt_q;
        dbus_rdt_d = dbus_rdt_q;
        lb_fill    = 1'b0;
        lb_inval   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbus_cyc) begin
                    owner_d_d = 1'b1;
                    m_adr_d   = dbus_adr[MEM_ADR_W+1:2];
                    m_we_d    = dbus_we;
                    m_dat_d   = dbus_dat;
                    m_sel_d   = dbus_sel;
                    if (d_in_range) begin
                        m_cyc_d  = 1'b1;
                        lb_inval = dbus_we;
                        state_d  = S_GRANT_D;
                    end else begin
                        dbus_ack_d = 1'b1;
                        dbus_rdt_d = '0;
                        state_d    = S_RESP;
                    end
                end else if (ibus_cyc) begin
                    owner_d_d = 1'b0;
                    m_adr_d   = ibus_adr[MEM_ADR_W+1:2];
                    m_we_d    = 1'b0;
                    m_dat_d   = '0;
                    m_sel_d   = IBUS_FULL_SEL;
                    if (!i_in_range || lb_hit) begin
                        // Answered locally: zero for out-of-range, buffered word on a hit.
                        ibus_ack_d = 1'b1;
                        ibus_rdt_d = i_in_range ? lb_dat : 32'h0;
                        state_d    = S_RESP;
                    end else begin
                        m_cyc_d = 1'b1;
                        state_d = S_GRANT_I;
                    end
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (m_ack) begin
                    m_cyc_d = 1'b0;
                    state_d = S_RESP;
                    lb_fill = !owner_d_q;
                    if (owner_d_q) begin
                        dbus_ack_d = 1'b1;
                        dbus_rdt_d = m_rdt;
                    end else begin
                        ibus_ack_d = 1'b1;
                        ibus_rdt_d = m_rdt;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_d_q  <= 1'b0;
            m_cyc_q    <= 1'b0;
            m_adr_q    <= '0;
            m_we_q     <= 1'b0;
            m_dat_q    <= '0;
            m_sel_q    <= '0;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            ibus_rdt_q <= '0;
            dbus_rdt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            m_cyc_q    <= m_cyc_d;
            m_adr_q    <= m_adr_d;
            m_we_q     <= m_we_d;
            m_dat_q    <= m_dat_d;
            m_sel_q    <= m_sel_d;
            ibus_ack_q <= ibus_ack_d;
            dbus_ack_q <= dbus_ack_d;
            ibus_rdt_q <= ibus_rdt_d;
            dbus_rdt_q <= dbus_rdt_d;
        end
    end

    assign m_cyc    = m_cyc_q;
    assign m_adr    = m_adr_q;
    assign m_we     = m_we_q;
    assign m_dat    = m_dat_q;
    assign m_sel    = m_sel_q;
    assign ibus_ack = ibus_ack_q;
    assign dbus_ack = dbus_ack_q;
    assign ibus_rdt = ibus_rdt_q;
    assign dbus_rdt = dbus_rdt_q;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Bench for serv_mem_arbiter: random and directed master traffic, a downstream memory responder and an ordered scoreboard.
// Latency: n/a.  Backpressure: responder picks random downstream latencies.
`timescale 1ns/1ps
module tb_serv_mem_arbiter;

    localparam int W = 14;
`ifdef IBUS_LINE_BUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  ibus_adr = '0;
    logic         ibus_cyc = 1'b0;
    logic [31:0]  ibus_rdt;
    logic         ibus_ack;
    logic [31:0]  dbus_adr = '0;
    logic [31:0]  dbus_dat = '0;
    logic [3:0]   dbus_sel = '0;
    logic         dbus_we = 1'b0;
    logic         dbus_cyc = 1'b0;
    logic [31:0]  dbus_rdt;
    logic         dbus_ack;
    logic         m_cyc;
    logic [W-1:0] m_adr;
    logic         m_we;
    logic [31:0]  m_dat;
    logic [3:0]   m_sel;
    logic [31:0]  m_rdt = '0;
    logic         m_ack = 1'b0;

    serv_mem_arbiter #(.MEM_ADR_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
        .dbus_adr(dbus_adr), .dbus_dat(dbus_dat), .dbus_sel(dbus_sel), .dbus_we(dbus_we),
        .dbus_cyc(dbus_cyc), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
        .m_cyc(m_cyc), .m_adr(m_adr), .m_we(m_we), .m_dat(m_dat), .m_sel(m_sel),
        .m_rdt(m_rdt), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] adr;
        logic         we;
        logic [31:0]  dat;
        logic [3:0]   sel;
    } mreq_t;

    typedef struct {
        bit          chk;
        logic [31:0] dat;
    } rsp_t;

    mreq_t        exp_m[$];
    rsp_t         exp_i[$];
    rsp_t         exp_d[$];
    logic [31:0]  rmem[int];
    logic [31:0]  smem[int];
    bit           lb_vld = 1'b0;
    logic [W-1:0] lb_tag = '0;
    logic [31:0]  lb_dat = '0;
    int           force_lat = 0;
    int           errors = 0;
    int           checks = 0;

    function automatic logic [31:0] init_word(int a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] dat, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(int w);
        if (rmem.exists(w)) return rmem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] rd_slv(int w);
        if (smem.exists(w)) return smem[w];
        return init_word(w);
    endfunction

    function automatic bit in_range(logic [31:0] a);
        return (a >> (W + 2)) == 32'h0;
    endfunction

    task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_req(string nm, mreq_t q);
        checks++;
        if (m_adr !== q.adr || m_we !== q.we || m_dat !== q.dat || m_sel !== q.sel) begin
            errors++;
            $display("FAIL %s: got adr=%h we=%b dat=%h sel=%b expected adr=%h we=%b dat=%h sel=%b",
                     nm, m_adr, m_we, m_dat, m_sel, q.adr, q.we, q.dat, q.sel);
        end
    endtask

    // Reference model: what each request should produce, evaluated in service order.
    task automatic model_d(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, output bit fast);
        rsp_t  r;
        mreq_t q;
        int    w;
        fast = 1'b0;
        if (!in_range(adr)) begin
            r.chk = 1'b1; r.dat = 32'h0; fast = 1'b1;
        end else begin
            w = int'(adr[W+1:2]);
            q.adr = adr[W+1:2]; q.we = we; q.dat = dat; q.sel = sel;
            exp_m.push_back(q);
            if (we) begin
                rmem[w] = merge(rd_ref(w), dat, sel);
                r.chk = 1'b0; r.dat = 32'h0;
                if (LB && lb_vld && lb_tag == q.adr) lb_vld = 1'b0;
            end else begin
                r.chk = 1'b1; r.dat = rd_ref(w);
            end
        end
        exp_d.push_back(r);
    endtask

    task automatic model_i(input logic [31:0] adr, output bit fast);
        rsp_t  r;
        mreq_t q;
        fast = 1'b0;
        r.chk = 1'b1;
        if (!in_range(adr)) begin
            r.dat = 32'h0; fast = 1'b1;
        end else if (LB && lb_vld && lb_tag == adr[W+1:2]) begin
            r.dat = lb_dat; fast = 1'b1;
        end else begin
            q.adr = adr[W+1:2]; q.we = 1'b0; q.dat = 32'h0; q.sel = 4'b1111;
            exp_m.push_back(q);
            r.dat = rd_ref(int'(adr[W+1:2]));
            if (LB) begin
                lb_vld = 1'b1; lb_tag = adr[W+1:2]; lb_dat = r.dat;
            end
        end
        exp_i.push_back(r);
    endtask

    // Master driver: raise cyc, drop each master's cyc the cycle after its ack.
    task automatic run_txn(input bit ui, input bit ud, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dd, input logic [3:0] ds, input logic dw,
                           output int il, output int dl);
        bit fi, fd, ip, dp, ai, ad;
        int cnt;
        fi = 1'b0; fd = 1'b0;
        if (ud) model_d(da, dd, ds, dw, fd);
        if (ui) model_i(ia, fi);
        @(posedge clk); #1;
        ibus_adr = ia; dbus_adr = da; dbus_dat = dd; dbus_sel = ds; dbus_we = dw;
        ibus_cyc = ui; dbus_cyc = ud;
        ip = ui; dp = ud; cnt = 0; il = 0; dl = 0;
        while ((ip || dp) && cnt < 400) begin
            @(negedge clk);
            cnt++;
            ai = ip && ibus_ack;
            ad = dp && dbus_ack;
            if (ai) begin il = cnt; ip = 1'b0; end
            if (ad) begin dl = cnt; dp = 1'b0; end
            @(posedge clk); #1;
            if (ai) ibus_cyc = 1'b0;
            if (ad) dbus_cyc = 1'b0;
        end
        checks++;
        if (ip || dp) begin
            errors++;
            $display("FAIL txn_timeout: ibus pending=%0b dbus pending=%0b after %0d cycles, required none", ip, dp, cnt);
            ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        end
        // A locally answered request acks at the second observation after cyc is raised.
        if (ui && !ud && fi) check32("ibus_local_lat", 32'(il), 32'd2);
        if (ud && !ui && fd) check32("dbus_local_lat", 32'(dl), 32'd2);
    endtask

    // Downstream SPI-memory responder.
    initial begin : slave
        mreq_t q;
        int    lat;
        bit    ab;
        forever begin
            @(negedge clk);
            if (rst_n && m_cyc) begin
                if (exp_m.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL m_req: unexpected m_cyc at adr %h, required no downstream access", m_adr);
                    q = '{adr: m_adr, we: m_we, dat: m_dat, sel: m_sel};
                end else begin
                    q = exp_m.pop_front();
                    check_req("m_req", q);
                end
                lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
                ab = 1'b0;
                for (int k = 1; k < lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin ab = 1'b1; break; end
                    check_req("m_hold", q);
                end
                if (!ab) begin
                    m_ack = 1'b1;
                    if (m_we) begin
                        smem[int'(m_adr)] = merge(rd_slv(int'(m_adr)), m_dat, m_sel);
                        m_rdt = $urandom;
                    end else begin
                        m_rdt = rd_slv(int'(m_adr));
                    end
                    @(negedge clk);
                    m_ack = 1'b0;
                    m_rdt = $urandom;
                    check32("m_cyc_after_ack", {31'h0, m_cyc}, 32'h0);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a master sees an ack.
    initial begin : monitor
        rsp_t        r;
        logic [31:0] last_i, last_d;
        last_i = '0; last_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_i = '0; last_d = '0;
            end else begin
                if (ibus_ack) begin
                    if (exp_i.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL ibus_ack: got unexpected ack rdt=%h, required no ack", ibus_rdt);
                    end else begin
                        r = exp_i.pop_front();
                        check32("ibus_rdt", ibus_rdt, r.dat);
                    end
                    last_i = ibus_rdt;
                end else begin
                    check32("ibus_rdt_hold", ibus_rdt, last_i);
                end
                if (dbus_ack) begin
                    if (exp_d.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL dbus_ack: got unexpected ack rdt=%h, required no ack", dbus_rdt);
                    end else begin
                        r = exp_d.pop_front();
                        if (r.chk) check32("dbus_rdt", dbus_rdt, r.dat);
                    end
                    last_d = dbus_rdt;
                end else begin
                    check32("dbus_rdt_hold", dbus_rdt, last_d);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : main
        int          il, dl;
        logic [31:0] ia, da;
        mreq_t       q;
        int          kind;

        rmem[32'h40] = 32'hDEAD_BEEF;
        smem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check32("rst_m_cyc", {31'h0, m_cyc}, 32'h0);
        check32("rst_m_adr", 32'(m_adr), 32'h0);
        check32("rst_m_we", {31'h0, m_we}, 32'h0);
        check32("rst_m_dat", m_dat, 32'h0);
        check32("rst_m_sel", {28'h0, m_sel}, 32'h0);
        check32("rst_ibus_ack", {31'h0, ibus_ack}, 32'h0);
        check32("rst_dbus_ack", {31'h0, dbus_ack}, 32'h0);
        check32("rst_ibus_rdt", ibus_rdt, 32'h0);
        check32("rst_dbus_rdt", dbus_rdt, 32'h0);

        // Fetch with a 40-cycle downstream latency: grant + 40 + resp.
        force_lat = 40;
        run_txn(1, 0, 32'h0000_0100, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);
        check32("ibus_slow_lat", 32'(il), 32'd42);
        force_lat = 0;

        run_txn(0, 1, 32'h0, 32'h0000_0008, 32'h1234_5678, 4'b0011, 1'b1, il, dl);
        run_txn(1, 1, 32'h0000_0104, 32'h0000_0100, 32'h0, 4'hF, 1'b0, il, dl);
        checks++;
        if (!(dl > 0 && il > dl)) begin
            errors++;
            $display("FAIL both_order: got dbus ack at %0d ibus ack at %0d, required dbus first", dl, il);
        end
        run_txn(0, 1, 32'h0, 32'h0001_0000, 32'h0, 4'hF, 1'b0, il, dl);
        run_txn(1, 0, 32'h8000_0004, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);

        // Reset while the fetch is out on the SPI bus; its ack must never appear.
        force_lat = 30;
        q = '{adr: 14'h080, we: 1'b0, dat: 32'h0, sel: 4'b1111};
        exp_m.push_back(q);
        @(posedge clk); #1;
        ibus_adr = 32'h0000_0200; ibus_cyc = 1'b1;
        for (int k = 0; k < 10 && !m_cyc; k++) @(negedge clk);
        check32("rst_mid_grant", {31'h0, m_cyc}, 32'h1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; ibus_cyc = 1'b0;
        lb_vld = 1'b0;
        @(negedge clk);
        check32("rst_mid_m_cyc", {31'h0, m_cyc}, 32'h0);
        check32("rst_mid_ibus_ack", {31'h0, ibus_ack}, 32'h0);
        check32("rst_mid_dbus_ack", {31'h0, dbus_ack}, 32'h0);
        force_lat = 0;
        run_txn(1, 0, 32'h0000_0200, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);

`ifdef IBUS_LINE_BUF_EN
        run_txn(1, 0, 32'h0000_0020, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);
        run_txn(1, 0, 32'h0000_0020, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);
        check32("lb_hit_lat", 32'(il), 32'd2);
        run_txn(0, 1, 32'h0, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 1'b1, il, dl);
        run_txn(1, 0, 32'h0000_0020, 32'h0, 32'h0, 4'h0, 1'b0, il, dl);
        checks++;
        if (il <= 2) begin
            errors++;
            $display("FAIL lb_inval: got fetch ack at %0d, required a memory access (>2)", il);
        end
`endif

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 2));
            ia = {18'h0, 10'($urandom_range(0, 15)), 2'($urandom)} << 2;
            ia = {ia[31:4], 2'($urandom), 2'b00} | 32'($urandom_range(0, 3));
            da = ({26'h0, 4'($urandom_range(0, 15)), 2'b00}) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ia[$urandom_range(W + 2, 31)] = 1'b1;
            if ($urandom_range(0, 9) == 0) da[$urandom_range(W + 2, 31)] = 1'b1;
            run_txn(kind != 1, kind != 0, ia, da, $urandom, 4'($urandom_range(1, 15)),
                    1'($urandom), il, dl);
        end

        repeat (5) @(negedge clk);
        check32("drain_m", 32'(exp_m.size()), 32'h0);
        check32("drain_i", 32'(exp_i.size()), 32'h0);
        check32("drain_d", 32'(exp_d.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serv_mem_arbiter.md
# serv_mem_arbiter

Two-master Wishbone arbiter between the SerV core's instruction bus (ibus) and data bus (dbus) and the single Wishbone slave port of the external SPI memory controller. It picks one request, converts the 32-bit byte address to the controller's 14-bit word address, and holds the downstream request stable for the whole multi-cycle SPI transaction. It captures the read word and returns a one-cycle registered ack to the requesting master. Out-of-range accesses are answered locally without touching SPI.

## Interface
Parameters:
- MEM_ADR_W, 14, downstream word-address width; memory window is 2^(MEM_ADR_W+2) bytes starting at byte 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ibus_adr  in  32  instruction byte address; bits [1:0] ignored.
- ibus_cyc  in  1  instruction fetch request.
- ibus_rdt  out  32  fetched word, valid with ibus_ack.
- ibus_ack  out  1  one-cycle fetch acknowledge.
- dbus_adr  in  32  data byte address; bits [1:0] ignored.
- dbus_dat  in  32  write data.
- dbus_sel  in  4  byte selects.
- dbus_we  in  1  1 = write.
- dbus_cyc  in  1  data request.
- dbus_rdt  out  32  read word, valid with dbus_ack.
- dbus_ack  out  1  one-cycle data acknowledge.
- m_cyc  out  1  downstream request.
- m_adr  out  MEM_ADR_W  downstream word address = granted byte address [MEM_ADR_W+1:2].
- m_we  out  1  downstream write enable; 0 for ibus.
- m_dat  out  32  downstream write data; 0 for ibus.
- m_sel  out  4  downstream byte select; 4'b1111 for ibus.
- m_rdt  in  32  downstream read data, valid when m_ack=1.
- m_ack  in  1  downstream one-cycle acknowledge.

## Operation
- FSM states: S_IDLE, S_GRANT_I, S_GRANT_D, S_RESP.
- S_IDLE, dbus_cyc=1: latch dbus request into the m_* registers and record owner = D.
  - If in range, go to S_GRANT_D.
  - If out of range (any dbus_adr[31:MEM_ADR_W+2] bit set), go to S_RESP with read word 0; the write is dropped.
- S_IDLE, ibus_cyc=1 and dbus_cyc=0: same handling with owner = I, going to S_GRANT_I.
- Fixed priority: dbus wins a simultaneous request. ibus stays pending and is served next, with no starvation, because SerV stalls dbus until ibus progresses.
- S_GRANT_x: m_cyc=1 and all m_* outputs are held constant.
  - On m_ack=1: capture m_rdt into the read register, clear m_cyc, go to S_RESP.
- S_RESP: the owner's ack is 1 for exactly one cycle; the owner's rdt equals the captured word.
  - Next state is always S_IDLE.
- Masters deassert cyc the cycle after their ack (Wishbone classic). Arbiter behaviour is undefined if they do not.
- A master dropping cyc while granted does not abort the transaction: the SPI transfer completes and the ack is still issued.
- m_ack outside S_GRANT_x is ignored.
- ibus_rdt and dbus_rdt hold their last value between acks.

## Timing
- Reset values: m_cyc=0, m_adr=0, m_we=0, m_dat=0, m_sel=0, ibus_ack=0, dbus_ack=0, ibus_rdt=0, dbus_rdt=0, state S_IDLE.
- All outputs are registered; there is no combinational path from m_ack to ibus_ack or dbus_ack.
- Latency from master cyc (sampled in S_IDLE) to master ack = 1 (grant) + downstream latency + 1 (resp).
- Out-of-range access: ack two cycles after cyc is sampled.
- m_cyc is low in the cycle following m_ack. The controller's post-ack idle state therefore never sees a stale request, and back-to-back transactions need no extra gap.
- Reset mid-transaction: state returns to S_IDLE and m_cyc=0 on the next edge. Any pending ack is lost. The controller shares rst_n and aborts its own transfer.

## Configuration
- IBUS_LINE_BUF_EN: adds a one-word instruction buffer (tag = word address, plus a valid bit).
  - In S_IDLE, an ibus request whose word address matches a valid tag goes straight to S_RESP and returns the buffered word; m_cyc stays 0 and ack comes 2 cycles after cyc is sampled.
  - Every ibus fetch completed from memory loads the buffer.
  - A dbus write whose word address matches the tag clears valid at grant.
  - Reset clears valid.
- Without the macro: every in-range ibus request goes to memory.

## Structure
- Package serv_mem_pkg holds:
  - arb_state_t enum;
  - MEM_ADR_W default;
  - IBUS_FULL_SEL constant (4'b1111).
- Optional sub-module ifetch_line_buf (tag/data/valid registers, hit compare, invalidate port), instantiated only under IBUS_LINE_BUF_EN.
- The FSM and m_* registers stay in the top module.

## Test plan
- ibus read at 0x0000_0100 with model returning 0xDEADBEEF after 40 cycles -> m_adr=0x040, m_we=0, m_sel=4'b1111; ibus_ack one cycle later with ibus_rdt=0xDEADBEEF; m_cyc low the cycle after m_ack.
- dbus write to 0x0000_0008, dat 0x12345678, sel 4'b0011 -> m_adr=0x002, m_we=1, m_sel=0011, m_dat=0x12345678 stable until m_ack; then a single dbus_ack; ibus_ack stays 0.
- ibus_cyc and dbus_cyc asserted in the same cycle -> dbus transaction runs first, then ibus without further stimulus; each ack goes only to its own master.
- dbus read at 0x0001_0000 -> no m_cyc; dbus_ack two cycles after cyc is sampled, dbus_rdt=0.
- rst_n low for one cycle during S_GRANT_I -> next cycle m_cyc=0 and all acks 0; a subsequent ibus request completes normally.
- With IBUS_LINE_BUF_EN: fetch 0x20 twice -> second fetch has no m_cyc and ack in 2 cycles. Then dbus write to 0x20 followed by a fetch of 0x20 -> memory is accessed again.
